// File: rtl/divider.sv
// Unsigned 8-bit restoring divider serving the controller's DIV instruction.
// One quotient bit per clock; Q/R/div_zero are updated together with a
// one-cycle div_complete pulse and hold until the next result.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for div_start; operands sampled on acceptance
// RUN   | eight shift/subtract iterations, count 0..7
// DONE  | one-cycle cooldown after a result; div_start ignored here
module divider (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] dA,
   input  logic [7:0] dB,
   input  logic       div_start,
   output logic [7:0] Q,
   output logic [7:0] R,
   output logic       div_complete,
   output logic       div_zero,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] q_sr;
   logic [7:0] divisor;
   logic [8:0] r;
   logic [2:0] count;

   logic [8:0] t;
   logic [8:0] diff;
   logic       ge;
   logic [8:0] r_next;
   logic [7:0] q_next;

   // One restoring step: bring down the next dividend bit and subtract if it fits.
   // r[8] is always zero between steps; folding it into the compare keeps the
   // step correct even if it were not.
   always_comb begin
      t      = {r[7:0], q_sr[7]};
      diff   = t - {1'b0, divisor};
      ge     = r[8] | (t >= {1'b0, divisor});
      r_next = ge ? diff : t;
      q_next = {q_sr[6:0], ge};
   end

   // Control FSM, datapath registers and registered result outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         q_sr         <= 8'd0;
         divisor      <= 8'd0;
         r            <= 9'd0;
         count        <= 3'd0;
         Q            <= 8'd0;
         R            <= 8'd0;
         div_complete <= 1'b0;
         div_zero     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               div_complete <= 1'b0;
               if (div_start) begin
                  busy <= 1'b1;
                  if (dB != 8'd0) begin
                     q_sr    <= dA;
                     divisor <= dB;
                     r       <= 9'd0;
                     count   <= 3'd0;
                     state   <= RUN;
                  end else begin
                     // Divide by zero resolves immediately with saturated quotient.
                     Q            <= 8'hFF;
                     R            <= dA;
                     div_zero     <= 1'b1;
                     div_complete <= 1'b1;
                     state        <= DONE;
                  end
               end
            end
            RUN: begin
               q_sr  <= q_next;
               r     <= r_next;
               count <= count + 3'd1;
               if (count == 3'd7) begin
                  Q            <= q_next;
                  R            <= r_next[7:0];
                  div_zero     <= 1'b0;
                  div_complete <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               div_complete <= 1'b0;
               busy         <= 1'b0;
               state        <= IDLE;
            end
            default: begin
               div_complete <= 1'b0;
               busy         <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule
